// File: rtl/ahb_bus_ctrl.sv
// ahb_bus_ctrl
// Two-master bus controller. Arbitrates round-robin between master 1 and
// master 2, sequences the shared address/write-data path through
// LOAD -> ADDR -> DATA, and closes each transfer on the slave ready returned
// through the read mux.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous active-low reset
//   req1/req2      transfer request (level, held until done)
//   write1/write2  direction of the requested transfer (1 = write)
//   rdyout         slave ready from read mux (looked at only in DATA)
//   respout        slave response, 2'b01 = ERROR
//   grant1/grant2  bus granted to master 1 / 2
//   sel1/sel2      address register load enable, master 1 / 2
//   sel3/sel4      write-data register load enable, master 1 / 2
//   mux1/mux2      address / data mux select (0 = master 1, 1 = master 2)
//   Aout/Dout      address / write-data tri-state enables
//   hwrite         direction of the current transfer
//   done1/done2    one-cycle completion pulse
//   err            one-cycle pulse with done on ERROR response or timeout
//
// Build option: define TIMEOUT_EN to abort a transfer after TIMEOUT wait
// cycles in DATA (done and err pulse together). Without it DATA waits
// indefinitely for rdyout.
//
// state | meaning
// IDLE  | bus free, requests sampled, all enables off
// LOAD  | winner's address (and write data) registers loaded
// ADDR  | address driven onto the bus
// DATA  | address held, write data driven, waiting for rdyout

module ahb_bus_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req1,
    input  logic       req2,
    input  logic       write1,
    input  logic       write2,
    input  logic       rdyout,
    input  logic [1:0] respout,
    output logic       grant1,
    output logic       grant2,
    output logic       sel1,
    output logic       sel2,
    output logic       sel3,
    output logic       sel4,
    output logic       mux1,
    output logic       mux2,
    output logic       Aout,
    output logic       Dout,
    output logic       hwrite,
    output logic       done1,
    output logic       done2,
    output logic       err
);

    if (TIMEOUT == 0 || TIMEOUT > 255) begin : g_bad_timeout
        $error("ahb_bus_ctrl: TIMEOUT must be in 1..255");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ADDR = 2'd2,
        DATA = 2'd3
    } state_t;

    state_t state_q, state_d;
    logic   owner_q, owner_d;   // 0 = master 1, 1 = master 2
    logic   last_q, last_d;     // master granted most recently
    logic   wr_q, wr_d;         // direction latched for the transfer

    logic grant1_q, grant1_d;
    logic grant2_q, grant2_d;
    logic sel1_q, sel1_d;
    logic sel2_q, sel2_d;
    logic sel3_q, sel3_d;
    logic sel4_q, sel4_d;
    logic mux_q, mux_d;
    logic aout_q, aout_d;
    logic dout_q, dout_d;
    logic hwrite_q, hwrite_d;
    logic done1_q, done1_d;
    logic done2_q, done2_d;
    logic err_q, err_d;
    logic busy_d;

`ifdef TIMEOUT_EN
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
    logic [7:0] wait_q, wait_d;
`endif

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        wr_d    = wr_q;
        done1_d = 1'b0;
        done2_d = 1'b0;
        err_d   = 1'b0;
`ifdef TIMEOUT_EN
        wait_d  = wait_q;
`endif
        case (state_q)
            IDLE: begin
                // During the done cycle the finishing master still holds its
                // request; skip that cycle so a stale request is not re-granted.
                if (!(done1_q | done2_q) && (req1 | req2)) begin
                    if (req1 && req2) begin
                        owner_d = ~last_q;
                    end else begin
                        owner_d = req2;
                    end
                    last_d  = owner_d;
                    wr_d    = owner_d ? write2 : write1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                state_d = ADDR;
            end
            ADDR: begin
                state_d = DATA;
`ifdef TIMEOUT_EN
                wait_d  = '0;
`endif
            end
            DATA: begin
                if (rdyout) begin
                    state_d = IDLE;
                    done1_d = ~owner_q;
                    done2_d = owner_q;
                    err_d   = (respout == 2'b01);
                end
`ifdef TIMEOUT_EN
                // This wait cycle would bring the count to TIMEOUT: abort.
                else if (wait_q == WAIT_LAST) begin
                    state_d = IDLE;
                    done1_d = ~owner_q;
                    done2_d = owner_q;
                    err_d   = 1'b1;
                end else begin
                    wait_d  = wait_q + 8'd1;
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Registered outputs decoded from the next state.
        busy_d   = (state_d != IDLE);
        grant1_d = busy_d & ~owner_d;
        grant2_d = busy_d & owner_d;
        sel1_d   = (state_d == LOAD) & ~owner_d;
        sel2_d   = (state_d == LOAD) & owner_d;
        sel3_d   = sel1_d & wr_d;
        sel4_d   = sel2_d & wr_d;
        mux_d    = busy_d & owner_d;
        aout_d   = (state_d == ADDR) || (state_d == DATA);
        dout_d   = (state_d == DATA) & wr_d;
        hwrite_d = busy_d & wr_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            wr_q     <= 1'b0;
            grant1_q <= 1'b0;
            grant2_q <= 1'b0;
            sel1_q   <= 1'b0;
            sel2_q   <= 1'b0;
            sel3_q   <= 1'b0;
            sel4_q   <= 1'b0;
            mux_q    <= 1'b0;
            aout_q   <= 1'b0;
            dout_q   <= 1'b0;
            hwrite_q <= 1'b0;
            done1_q  <= 1'b0;
            done2_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            wr_q     <= wr_d;
            grant1_q <= grant1_d;
            grant2_q <= grant2_d;
            sel1_q   <= sel1_d;
            sel2_q   <= sel2_d;
            sel3_q   <= sel3_d;
            sel4_q   <= sel4_d;
            mux_q    <= mux_d;
            aout_q   <= aout_d;
            dout_q   <= dout_d;
            hwrite_q <= hwrite_d;
            done1_q  <= done1_d;
            done2_q  <= done2_d;
            err_q    <= err_d;
        end
    end

`ifdef TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end
`endif

    assign grant1 = grant1_q;
    assign grant2 = grant2_q;
    assign sel1   = sel1_q;
    assign sel2   = sel2_q;
    assign sel3   = sel3_q;
    assign sel4   = sel4_q;
    assign mux1   = mux_q;
    assign mux2   = mux_q;
    assign Aout   = aout_q;
    assign Dout   = dout_q;
    assign hwrite = hwrite_q;
    assign done1  = done1_q;
    assign done2  = done2_q;
    assign err    = err_q;

endmodule

// File: tb/tb_ahb_bus_ctrl.sv
// Testbench for ahb_bus_ctrl. Expected completions (master, err, cycle) are
// queued when a transfer is launched and compared when done1/done2 fires.

module tb_ahb_bus_ctrl;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       req1, req2, write1, write2, rdyout;
    logic [1:0] respout;
    logic       grant1, grant2, sel1, sel2, sel3, sel4;
    logic       mux1, mux2, Aout, Dout, hwrite, done1, done2, err;
    logic [13:0] outs;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        int   m;
        logic e;
        int   cyc;
    } exp_t;

    exp_t sb[$];

    ahb_bus_ctrl #(.TIMEOUT(TO)) dut (
        .clk     (clk),
        .rst     (rst),
        .req1    (req1),
        .req2    (req2),
        .write1  (write1),
        .write2  (write2),
        .rdyout  (rdyout),
        .respout (respout),
        .grant1  (grant1),
        .grant2  (grant2),
        .sel1    (sel1),
        .sel2    (sel2),
        .sel3    (sel3),
        .sel4    (sel4),
        .mux1    (mux1),
        .mux2    (mux2),
        .Aout    (Aout),
        .Dout    (Dout),
        .hwrite  (hwrite),
        .done1   (done1),
        .done2   (done2),
        .err     (err)
    );

    assign outs = {grant1, grant2, sel1, sel2, sel3, sel4, mux1, mux2,
                   Aout, Dout, hwrite, done1, done2, err};

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Invariants every cycle, plus scoreboard compare on each completion.
    always @(negedge clk) begin : mon
        exp_t e;
        chk("grant_excl", int'(grant1 & grant2), 0);
        chk("sel_addr_excl", int'(sel1 & sel2), 0);
        chk("sel_data_excl", int'(sel3 & sel4), 0);
        chk("err_needs_done", int'(err & ~(done1 | done2)), 0);
        if (done1 | done2) begin
            chk("done_both", int'(done1 & done2), 0);
            chk("sb_nonempty", int'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("done_master", done2 ? 2 : 1, e.m);
                chk("done_err", int'(err), int'(e.e));
                chk("done_cycle", cyc, e.cyc);
            end
        end
    end

    // Caller is just after a negedge with the DUT idle and no done pending.
    task automatic do_xfer(input int m, input logic wr, input int waits,
                           input logic [1:0] resp, input logic abort);
        exp_t e;
        int   k;
        int   n;
        e.m   = m;
        e.e   = abort | (resp == 2'b01);
        e.cyc = abort ? (cyc + 3 + TO) : (cyc + 4 + waits);
        sb.push_back(e);
        if (m == 1) begin
            req1 = 1'b1; write1 = wr; write2 = ~wr;
        end else begin
            req2 = 1'b1; write2 = wr; write1 = ~wr;
        end
        @(negedge clk);
        chk("load_grant1", int'(grant1), int'(m == 1));
        chk("load_grant2", int'(grant2), int'(m == 2));
        chk("load_sel1", int'(sel1), int'(m == 1));
        chk("load_sel2", int'(sel2), int'(m == 2));
        chk("load_sel3", int'(sel3), int'(m == 1 && wr));
        chk("load_sel4", int'(sel4), int'(m == 2 && wr));
        chk("load_mux1", int'(mux1), int'(m == 2));
        chk("load_mux2", int'(mux2), int'(m == 2));
        chk("load_hwrite", int'(hwrite), int'(wr));
        chk("load_aout", int'(Aout), 0);
        req1 = 1'b0;
        req2 = 1'b0;
        @(negedge clk);
        chk("addr_aout", int'(Aout), 1);
        chk("addr_dout", int'(Dout), 0);
        chk("addr_sels", int'({sel1, sel2, sel3, sel4}), 0);
        chk("addr_grant", int'(m == 1 ? grant1 : grant2), 1);
        @(negedge clk);
        chk("data_aout", int'(Aout), 1);
        chk("data_dout", int'(Dout), int'(wr));
        k       = waits;
        rdyout  = (k == 0) && !abort;
        respout = rdyout ? resp : 2'b01;
        n       = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            #1;
            n++;
            if (sb.size() != 0) begin
                chk("dout_wait", int'(Dout), int'(wr));
                k--;
                rdyout  = (k == 0) && !abort;
                respout = rdyout ? resp : 2'b01;
            end
        end
        chk("done_within_bound", sb.size(), 0);
        sb.delete();
        rdyout  = 1'b0;
        respout = 2'b00;
        @(negedge clk);
        #1;
        chk("idle_outs", int'(outs), 0);
    endtask

    initial begin
        int n;
        exp_t e;
        rst = 1'b1;
        req1 = 1'b0; req2 = 1'b0; write1 = 1'b0; write2 = 1'b0;
        rdyout = 1'b0; respout = 2'b00;
        #2 rst = 1'b0;
        #1 chk("reset_outs", int'(outs), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;

        do_xfer(1, 1'b1, 0, 2'b00, 1'b0);
        do_xfer(2, 1'b0, 3, 2'b00, 1'b0);
        do_xfer(1, 1'b1, 0, 2'b01, 1'b0);
        do_xfer(2, 1'b1, 1, 2'b00, 1'b0);
`ifdef TIMEOUT_EN
        do_xfer(1, 1'b1, 0, 2'b00, 1'b1);
        do_xfer(1, 1'b1, TO - 1, 2'b00, 1'b0);
`else
        do_xfer(1, 1'b0, 20, 2'b00, 1'b0);
`endif

        // Asynchronous reset in the middle of a write's DATA phase.
        req1 = 1'b1; write1 = 1'b1; rdyout = 1'b0;
        @(negedge clk);
        req1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_aout", int'(Aout), 1);
        #2 rst = 1'b0;
        #1 chk("rst_async_outs", int'(outs), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;

        // Both masters held high: 1,2,1,2 every 5 cycles, master 1 first.
        req1 = 1'b1; req2 = 1'b1; write1 = 1'b1; write2 = 1'b0;
        rdyout = 1'b1; respout = 2'b00;
        for (int i = 0; i < 4; i++) begin
            e.m   = (i % 2 == 0) ? 1 : 2;
            e.e   = 1'b0;
            e.cyc = cyc + 4 + 5 * i;
            sb.push_back(e);
        end
        @(negedge clk);
        chk("tie_grant1", int'(grant1), 1);
        chk("tie_grant2", int'(grant2), 0);
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("fair_within_bound", sb.size(), 0);
        sb.delete();
        req1 = 1'b0; req2 = 1'b0; rdyout = 1'b0;
        repeat (3) @(negedge clk);
        chk("final_idle", int'(outs), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ahb_bus_ctrl.md
# ahb_bus_ctrl

Two-master bus controller that sequences the shared address/write-data datapath and the read-response mux. Arbitrates between master 1 and master 2 round-robin. Drives the register-load enables, mux selects and tri-state enables so one transfer at a time owns the bus. Closes each transfer on the slave ready returned through the read mux.

## Interface
Parameters:
- TIMEOUT, 16: wait-state limit in DATA, in cycles; legal 1..255 (used only with TIMEOUT_EN).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- req1, req2  in  1  transfer request from master 1 / master 2; level, held until done
- write1, write2  in  1  direction of the requested transfer (1 = write)
- rdyout  in  1  slave ready from read mux
- respout  in  2  slave response from read mux; 2'b01 = ERROR, others = OKAY
- grant1, grant2  out  1  bus granted to master 1 / 2
- sel1, sel2  out  1  load enable, address register of master 1 / 2
- sel3, sel4  out  1  load enable, write-data register of master 1 / 2
- mux1  out  1  address mux select (0 = master 1, 1 = master 2)
- mux2  out  1  data mux select (same encoding)
- Aout  out  1  address tri-state enable
- Dout  out  1  write-data tri-state enable
- hwrite  out  1  direction of current transfer
- done1, done2  out  1  one-cycle completion pulse to master 1 / 2
- err  out  1  one-cycle pulse with done when transfer ended in ERROR or timeout

## Operation
- States: IDLE, LOAD, ADDR, DATA. All outputs registered (Moore, decoded from next state).
- IDLE: all enables 0, grants 0. Requests sampled only here. If any req, pick winner, go LOAD.
- Arbitration: round-robin pointer = last master granted. If both requesting, grant the other one. Single requester always wins. Pointer resets to "last = master 2", so master 1 wins first tie.
- LOAD (1 cycle): grantN=1. Address load enable of winner = 1 (sel1 or sel2). Its data load enable (sel3/sel4) = 1 only if its write = 1. mux1 = mux2 = winner. hwrite = winner's write, latched for the transfer.
- ADDR (1 cycle): Aout=1, grant, mux and hwrite held, sel* = 0.
- DATA: Aout=1, Dout=hwrite. Stay while rdyout=0. On rdyout=1 go IDLE. Pulse doneN for one cycle. Pulse err if respout==2'b01 in the same sample.
- Return to IDLE clears grant, Aout, Dout, mux1/mux2 (to 0) and hwrite. At least one IDLE cycle between transfers.
- Request deassertion after LOAD is ignored; the transfer runs to completion.
- rdyout/respout outside DATA are ignored.
- sel1 and sel2 never both 1; sel3 and sel4 never both 1; grant1 and grant2 never both 1.

## Timing
- Reset: async assert forces state IDLE and every output 0 immediately, including mid-transfer. Pointer = master 2. Deassertion is synchronous to clk.
- Request sampled at edge E0 in IDLE. Edge E0 produces LOAD outputs and E1 produces ADDR. DATA outputs appear at E2.
- Zero-wait transfer: rdyout=1 in first DATA cycle. done is visible after edge E3. req to done = 4 cycles.
- Each wait cycle (rdyout=0) adds one cycle.
- Back-to-back requests: next LOAD starts 1 cycle after done, so a transfer every 5 cycles minimum.

## Configuration
- TIMEOUT_EN defined:
  - 8-bit wait counter clears on entry to DATA and increments each DATA cycle with rdyout=0.
  - When the count reaches TIMEOUT, the transfer aborts: go IDLE, pulse doneN and err together.
  - rdyout=1 in the same cycle as the count reaching TIMEOUT wins; the transfer completes normally, with err set only by respout.
- TIMEOUT_EN undefined: no counter, no TIMEOUT logic; DATA waits indefinitely for rdyout.

## Test plan
- Reset mid-DATA: assert rst=0 during a write → Aout, Dout, grant1, sel* all 0 the same cycle. After release, req1+req2 together → grant1 first.
- Single write: req1=1, write1=1, rdyout=1 from first DATA cycle → cycle 1 sel1=sel3=1, mux=0. Cycles 2–3 Aout=1, Dout=1 in cycle 3. done1 pulse 4 cycles after req, err=0.
- Read: req2=1, write2=0 → sel2=1, sel4=0, mux1=mux2=1, Dout never 1. Hold rdyout=0 for 3 DATA cycles → done2 delayed by exactly 3 cycles.
- Fairness: req1 and req2 held high continuously → grants alternate 1,2,1,2 with a 5-cycle period. grant1 and grant2 never overlap.
- Error response: rdyout=1 with respout=2'b01 → done and err pulse in the same cycle for one cycle. Next transfer proceeds normally.
- TIMEOUT_EN, TIMEOUT=4, rdyout stuck 0 → abort after 4 DATA cycles with done1=err=1, then IDLE. Repeat with rdyout=1 on 4th cycle → err=0.
